// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the RV32 core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and selects, traps and counts retires.
module mc_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Last wait-counter value on which an ack is still honoured.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        bus_err_q, bus_err_d;
    logic        halted_q, halted_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    logic        imem_req_c, ir_we_c, dmem_req_c, dmem_we_c;
    logic        alu_a_sel_c, alu_b_sel_c, rf_we_c, pc_we_c;
    logic [1:0]  wb_sel_c, pc_sel_c;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        halted_d    = halted_q;
        retire      = 1'b0;
        imem_req_c  = 1'b0;
        ir_we_c     = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 1'b0;
        wb_sel_c    = 2'd0;
        rf_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 2'd0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: state_d = S_EXEC;
                    OP_SYSTEM: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_IMM, OP_LOAD, OP_STORE, OP_JALR: alu_b_sel_c = 1'b1;
                    OP_AUIPC: begin
                        alu_a_sel_c = 1'b1;
                        alu_b_sel_c = 1'b1;
                    end
                    default: ;
                endcase
                if (opcode == OP_BRANCH) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = branch_taken ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OP_STORE);
                if (dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (opcode)
                    OP_LOAD:          wb_sel_c = 2'd1;
                    OP_JAL, OP_JALR:  wb_sel_c = 2'd2;
                    OP_LUI:           wb_sel_c = 2'd3;
                    default:          wb_sel_c = 2'd0;
                endcase
                case (opcode)
                    OP_JAL:  pc_sel_c = 2'd1;
                    OP_JALR: pc_sel_c = 2'd2;
                    default: pc_sel_c = 2'd0;
                endcase
            end
            default: ;
        endcase

        // Every state change starts a fresh wait window for FETCH and MEM.
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            halted_q  <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
        end
    end

    // Outputs are forced low for as long as reset is held, not just after its edge.
    assign imem_req  = rst_n & imem_req_c;
    assign ir_we     = rst_n & ir_we_c;
    assign dmem_req  = rst_n & dmem_req_c;
    assign dmem_we   = rst_n & dmem_we_c;
    assign alu_a_sel = rst_n & alu_a_sel_c;
    assign alu_b_sel = rst_n & alu_b_sel_c;
    assign wb_sel    = rst_n ? wb_sel_c : 2'd0;
    assign rf_we     = rst_n & rf_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign pc_sel    = rst_n ? pc_sel_c : 2'd0;
    assign illegal   = rst_n & illegal_q;
    assign bus_err   = rst_n & bus_err_q;
    assign halted    = rst_n & halted_q;
    assign instret   = rst_n ? instret_q : 32'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl (TIMEOUT = 4) plus hand sequences for
// traps, timeouts, reset mid-access and instret wrap.
module tb_mc_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        imem_req, imem_ack = 1'b0, ir_we;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic        alu_a_sel, alu_b_sel, rf_we, pc_we;
    logic [1:0]  wb_sel, pc_sel;
    logic        illegal, bus_err, halted;
    logic [31:0] instret;

    mc_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .illegal(illegal), .bus_err(bus_err), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         iw;
        int         dw;
        int         cyc;
        int         nrf;
        logic [1:0] wb;
        logic [1:0] pcs;
        logic       chk_sel;
        logic       a;
        logic       b;
        logic       dwe;
        int         nireq;
        int         ndreq;
    } vec_t;

    typedef struct {
        int         cycles;
        int         n_ireq;
        int         n_dreq;
        int         n_ir;
        int         n_rf;
        int         n_pc;
        logic [1:0] wb;
        logic [1:0] pcs;
        logic       a;
        logic       b;
        logic       dwe;
    } obs_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret = 32'd0;
    vec_t        vecs[11];

    task automatic chk(input string what, input int idx, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", what, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic bt, input int iw, input int dw,
                                input int cyc, input int nrf, input logic [1:0] wb,
                                input logic [1:0] pcs, input logic chk_sel, input logic a,
                                input logic b, input logic dwe, input int nireq, input int ndreq);
        vec_t v;
        v.op = op; v.bt = bt; v.iw = iw; v.dw = dw; v.cyc = cyc; v.nrf = nrf;
        v.wb = wb; v.pcs = pcs; v.chk_sel = chk_sel; v.a = a; v.b = b; v.dwe = dwe;
        v.nireq = nireq; v.ndreq = ndreq;
        return v;
    endfunction

    // Steps one instruction from its first FETCH cycle; stops on pc_we or after max_cyc.
    task automatic run_instr(input logic [6:0] op, input logic bt, input int iw, input int dw,
                             input int max_cyc, output obs_t o);
        bit done = 0;
        o = '{default: 0};
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            opcode       = op;
            branch_taken = bt;
            imem_ack     = imem_req && (o.n_ireq == iw);
            dmem_ack     = dmem_req && (o.n_dreq == dw);
            #1;
            if (imem_req) o.n_ireq++;
            if (dmem_req) begin
                o.n_dreq++;
                if (dmem_we) o.dwe = 1'b1;
            end
            if (c == iw + 2) begin
                o.a = alu_a_sel;
                o.b = alu_b_sel;
            end
            if (ir_we) o.n_ir++;
            if (rf_we) begin
                o.n_rf++;
                o.wb = wb_sel;
            end
            if (pc_we) begin
                o.n_pc++;
                o.pcs = pc_sel;
                done  = 1;
            end
            o.cycles = c + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("reset_outs", -1, {imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
                               wb_sel, rf_we, pc_we, pc_sel, illegal, bus_err, halted,
                               instret}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("first_imem_req", -1, imem_req, 1);
        chk("flags_after_reset", -1, {illegal, bus_err, halted}, 0);
        chk("instret_after_reset", -1, instret, 0);
        exp_instret = 32'd0;
    endtask

    // Runs one table entry that is expected to retire, then checks instret after the retire edge.
    task automatic apply(input int i);
        obs_t o;
        vec_t v;
        v = vecs[i];
        run_instr(v.op, v.bt, v.iw, v.dw, 40, o);
        chk("cycles", i, o.cycles, v.cyc);
        chk("imem_req_cycles", i, o.n_ireq, v.nireq);
        chk("dmem_req_cycles", i, o.n_dreq, v.ndreq);
        chk("ir_we_pulses", i, o.n_ir, 1);
        chk("pc_we_pulses", i, o.n_pc, 1);
        chk("rf_we_pulses", i, o.n_rf, v.nrf);
        if (v.nrf != 0) chk("wb_sel", i, o.wb, v.wb);
        chk("pc_sel", i, o.pcs, v.pcs);
        if (v.chk_sel) chk("alu_sel_ab", i, {o.a, o.b}, {v.a, v.b});
        chk("dmem_we", i, o.dwe, v.dwe);
        exp_instret = exp_instret + 32'd1;
        @(posedge clk);
        #1;
        chk("instret", i, instret, exp_instret);
        chk("flags", i, {illegal, bus_err, halted}, 0);
    endtask

    initial begin
        obs_t o;
        int   n;

        //            op          bt  iw dw cyc nrf wb pcs chk a  b  dwe nireq ndreq
        vecs[0]  = mk(7'b0010011, 0,  0, 0, 4,  1,  0, 0,  1,  0, 1, 0,  1,    0); // ADDI
        vecs[1]  = mk(7'b0000011, 0,  0, 2, 7,  1,  1, 0,  1,  0, 1, 0,  1,    3); // LW, 3-cycle req
        vecs[2]  = mk(7'b0100011, 0,  0, 0, 4,  0,  0, 0,  1,  0, 1, 1,  1,    1); // SW
        vecs[3]  = mk(7'b1100011, 1,  0, 0, 3,  0,  0, 1,  1,  0, 0, 0,  1,    0); // BEQ taken
        vecs[4]  = mk(7'b1100011, 0,  0, 0, 3,  0,  0, 0,  1,  0, 0, 0,  1,    0); // BEQ not taken
        vecs[5]  = mk(7'b1101111, 0,  0, 0, 4,  1,  2, 1,  0,  0, 0, 0,  1,    0); // JAL
        vecs[6]  = mk(7'b1100111, 0,  0, 0, 4,  1,  2, 2,  1,  0, 1, 0,  1,    0); // JALR
        vecs[7]  = mk(7'b0110011, 0,  3, 0, 7,  1,  0, 0,  1,  0, 0, 0,  4,    0); // ADD, ack on 4th fetch cycle
        vecs[8]  = mk(7'b0010111, 0,  0, 0, 4,  1,  0, 0,  1,  1, 1, 0,  1,    0); // AUIPC
        vecs[9]  = mk(7'b0110111, 0,  0, 0, 4,  1,  3, 0,  0,  0, 0, 0,  1,    0); // LUI
        vecs[10] = mk(7'b0100011, 0,  2, 3, 9,  0,  0, 0,  1,  0, 1, 1,  3,    4); // SW, ack on last MEM cycle

        do_reset();
        for (int i = 0; i < 11; i++) begin
            apply(i);
        end

        // Illegal (AMO) opcode: trap and stay there with no further fetches.
        run_instr(7'b0101111, 1'b0, 0, 0, 40, o);
        chk("amo_ir_we", 20, o.n_ir, 1);
        chk("amo_no_pc_we", 20, o.n_pc, 0);
        chk("amo_illegal", 20, {illegal, bus_err, halted}, 3'b100);
        chk("amo_instret", 20, instret, exp_instret);
        n = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (imem_req) n++;
        end
        chk("trap_no_imem_req", 20, n, 0);

        // SYSTEM halts.
        do_reset();
        run_instr(7'b1110011, 1'b0, 0, 0, 10, o);
        chk("sys_no_pc_we", 21, o.n_pc, 0);
        chk("sys_halted", 21, {illegal, bus_err, halted}, 3'b001);

        // Fetch timeout: no ack within TIMEOUT cycles.
        do_reset();
        run_instr(7'b0010011, 1'b0, TO, 0, 10, o);
        chk("to_imem_req_cycles", 22, o.n_ireq, TO);
        chk("to_no_ir_we", 22, o.n_ir, 0);
        chk("to_bus_err", 22, {illegal, bus_err, halted}, 3'b010);

        // Data timeout on a load.
        do_reset();
        run_instr(7'b0000011, 1'b0, 0, 99, 12, o);
        chk("dto_dmem_req_cycles", 23, o.n_dreq, TO);
        chk("dto_no_pc_we", 23, o.n_pc, 0);
        chk("dto_bus_err", 23, {illegal, bus_err, halted}, 3'b010);

        // Reset asserted mid-MEM after one retired instruction.
        do_reset();
        apply(0);
        run_instr(7'b0000011, 1'b0, 0, 99, 5, o);
        chk("midmem_dmem_req_cycles", 24, o.n_dreq, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmem_req_drop", 24, {dmem_req, imem_req, pc_we, rf_we}, 0);
        @(posedge clk);
        #1;
        chk("midmem_after_edge", 24, {dmem_req, pc_we, rf_we}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("midmem_fetch_next", 24, imem_req, 1);
        chk("midmem_flags", 24, {illegal, bus_err, halted}, 0);
        chk("midmem_instret", 24, instret, 0);
        exp_instret = 32'd0;

        // instret wrap.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        apply(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
